agn_msaw_seq: RTL and testbench
===============================

# agn_msaw_seq

Step sequencer for the modulated-sawtooth generator. Drives the generator's clock enable and 8-bit amplitude multiplier `M` from a small programmable step table. Holds each table entry for a programmed number of sawtooth periods, counted on the generator's `CO_MSAW` wrap flag. Sits between the control/register side and the sawtooth generator instance.

## Interface
Parameters:
- `NSTEP`, 8: table depth; power of two, 2..16. `SW = log2(NSTEP)`.
- `CE_DIV`, 10: `ce` pulse spacing in `clk` cycles; ≥1.
- `PER_W`, 8: width of the periods-per-step field.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset; one clock, asynchronous, active-low.
- `wr_valid` in 1: table write request.
- `wr_ready` out 1: table write accept.
- `wr_addr` in SW: table write index.
- `wr_data` in 8: table write value (`M` for that step).
- `start` in 1: start pulse; honoured in IDLE only.
- `stop` in 1: abort; honoured in SYNC/RUN.
- `n_per` in PER_W: periods per step; latched on accepted `start`.
- `n_step` in SW: last step index; latched on accepted `start`.
- `co_msaw` in 1: generator wrap flag.
- `ce` out 1: generator clock enable.
- `M` out 8: generator multiplier.
- `busy` out 1: high in SYNC/RUN/DONE.
- `done` out 1: one-cycle end-of-sequence pulse.
- `step_idx` out SW: current step.

## Operation
States: IDLE, SYNC, RUN, DONE.
- Reset values: state IDLE; `ce`=0, `M`=0, `busy`=0, `done`=0, `step_idx`=0. All table entries 0, divider 0, period counter 0. `wr_ready` = (state==IDLE), so it reads 1 after reset.
- **Table write:** committed on `wr_valid && wr_ready`. Writes issued outside IDLE are not accepted and the table is unchanged.
- **IDLE → SYNC on `start`:** latch `n_per` and `n_step`; if the latched `n_per` is 0, store 1. Set `M`=0 and clear the divider.
- **SYNC:** runs `ce` with `M`=0 so the free-running generator phase-aligns. On `co_msaw && ce`: go to RUN, `M`=table[0], `step_idx`=0, period count 0.
- **RUN:** each `co_msaw && ce` ends one period.
  - Period counter increments.
  - At count `n_per-1`: counter clears and the step advances, `M`=table[next] on the same edge as the generator's wrap to 0.
  - When leaving step `n_step`: go to DONE.
- **DONE:** exactly 1 cycle. `done`=1, `ce`=0, `M`=0. Then IDLE.
- **`stop` in SYNC/RUN:** next state IDLE, `ce`=0, `M`=0, `step_idx`=0. No `done`. The generator is frozen mid-ramp; the next SYNC realigns it.
- **Divider:** counts 0..CE_DIV-1 in SYNC/RUN, wraps, and `ce`=1 when it equals CE_DIV-1. With CE_DIV=1, `ce` is constantly 1 in SYNC/RUN. The divider is held at 0 in IDLE/DONE.
- **Simultaneous events:**
  - `start` together with an accepted write: the write commits. If both address step 0, the SYNC→RUN load later uses the new value, since the table is read at RUN entry.
  - `stop` together with a period end: `stop` wins.
  - `start` outside IDLE: ignored.
- `co_msaw` outside `ce` cycles is ignored.

## Timing
- All outputs are registered except `wr_ready`, which is combinational from state.
- `start` → `busy`=1 and SYNC: next edge. First `ce` appears CE_DIV cycles later.
- Generator period = (NP+1)·CE_DIV `clk`, where NP is the generator's wrap count.
- `M` change coincides with the `clk` edge where the generator counter reloads 0. No sample at the old amplitude follows a step change.
- Step length = `n_per`·(NP+1)·CE_DIV `clk`.
- `done` asserts the cycle after the last period end. `busy` falls the cycle after `done`.
- Asynchronous reset mid-operation: all outputs go to their reset values immediately, and the table is cleared.

## Configuration
- `AGN_SEQ_LOOP_EN` defined: RUN wraps from step `n_step` back to step 0 with `M`=table[0]. DONE is never entered and `done` never pulses. Only `stop` or reset ends the sequence.
- `AGN_SEQ_LOOP_EN` undefined: single pass, ending in DONE as above.

## Test plan
Bench uses the generator with NP=100, plus CE_DIV=2 and NSTEP=8. One period is 202 `clk`.
- **Reset:** assert `rst_n`=0 mid-RUN → `ce`/`M`/`busy`/`done`/`step_idx` go to 0 asynchronously, `wr_ready`=1, and table reads back 0 on the next run.
- **Single pass:** write {16,32,64,128} to addresses 0..3, `n_step`=3, `n_per`=2, pulse `start` → `M`=0 until the first wrap, then 16, 32, 64, 128 for 404 `clk` each. Each change lands on a generator wrap, then one `done` pulse, `busy` low, `ce`=0.
- **Stop:** in the same sequence, pulse `stop` during step 2 → next edge `M`=0, `ce`=0, `busy`=0, and no `done`.
- **Write lockout:** hold `wr_valid`=1, addr 0, data 255 during RUN → `wr_ready`=0 throughout. Next run step 0 still uses `M`=16.
- **Zero periods:** `n_per`=0, `n_step`=1 → each step lasts exactly 202 `clk`.
- **Loop:** with `AGN_SEQ_LOOP_EN`, run the single-pass table → after 128 `M` returns to 16, `done` stays 0 for at least 3 loops, and `stop` ends the sequence.

Source files
------------

// File: rtl/agn_msaw_seq.sv
// Step sequencer for the modulated-sawtooth generator: drives ce and M from a step table.
// AGN_SEQ_LOOP_EN: repeat the table until stop instead of a single pass ending in DONE.
module agn_msaw_seq #(
    parameter int NSTEP  = 8,
    parameter int CE_DIV = 10,
    parameter int PER_W  = 8,
    localparam int SW = $clog2(NSTEP),
    localparam int DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [SW-1:0]    wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic [PER_W-1:0] n_per,
    input  logic [SW-1:0]    n_step,
    input  logic             co_msaw,
    output logic             ce,
    output logic [7:0]       M,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    step_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [7:0]       tbl [NSTEP];
    logic [DW-1:0]    div_q, div_n;
    logic [PER_W-1:0] per_q, per_n;
    logic [PER_W-1:0] np_q, np_n;
    logic [SW-1:0]    ns_q, ns_n;
    logic [SW-1:0]    step_n, step_nx;
    logic [7:0]       m_n;
    logic             ce_n, act, act_n, ev;

    assign wr_ready = (state == S_IDLE);
    assign act      = (state == S_SYNC) || (state == S_RUN);
    assign act_n    = (state_n == S_SYNC) || (state_n == S_RUN);
    assign ev       = ce && co_msaw;
    assign step_nx  = step_idx + SW'(1);

    always_comb begin
        state_n = state;
        m_n     = M;
        step_n  = step_idx;
        per_n   = per_q;
        np_n    = np_q;
        ns_n    = ns_q;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SYNC;
                    np_n    = (n_per == '0) ? PER_W'(1) : n_per;
                    ns_n    = n_step;
                    m_n     = '0;
                    step_n  = '0;
                    per_n   = '0;
                end
            end
            S_SYNC: begin
                if (stop) begin
                    state_n = S_IDLE;
                    m_n     = '0;
                    step_n  = '0;
                end else if (ev) begin
                    state_n = S_RUN;
                    m_n     = tbl[0];
                    step_n  = '0;
                    per_n   = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_n = S_IDLE;
                    m_n     = '0;
                    step_n  = '0;
                end else if (ev) begin
                    if (per_q == np_q - PER_W'(1)) begin
                        per_n = '0;
                        if (step_idx == ns_q) begin
`ifdef AGN_SEQ_LOOP_EN
                            step_n = '0;
                            m_n    = tbl[0];
`else
                            state_n = S_DONE;
                            m_n     = '0;
`endif
                        end else begin
                            step_n = step_nx;
                            m_n    = tbl[step_nx];
                        end
                    end else begin
                        per_n = per_q + PER_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                m_n     = '0;
            end
        endcase
    end

    // divider only runs while staying active; any entry into SYNC restarts it
    always_comb begin
        div_n = '0;
        if (act && act_n)
            div_n = (div_q == DW'(CE_DIV - 1)) ? '0 : div_q + DW'(1);
        ce_n = act_n && (div_n == DW'(CE_DIV - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            div_q    <= '0;
            per_q    <= '0;
            np_q     <= '0;
            ns_q     <= '0;
            ce       <= 1'b0;
            M        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_idx <= '0;
        end else begin
            state    <= state_n;
            div_q    <= div_n;
            per_q    <= per_n;
            np_q     <= np_n;
            ns_q     <= ns_n;
            ce       <= ce_n;
            M        <= m_n;
            busy     <= (state_n != S_IDLE);
            done     <= (state_n == S_DONE);
            step_idx <= step_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTEP; i++)
                tbl[i] <= '0;
        end else if (wr_valid && wr_ready) begin
            tbl[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_agn_msaw_seq.sv
// Bench for agn_msaw_seq with a behavioural sawtooth generator (NP=100) and step-table model.
// Honours AGN_SEQ_LOOP_EN to expect looping instead of a single pass.
module tb_agn_msaw_seq;

    localparam int NSTEP  = 8;
    localparam int CE_DIV = 2;
    localparam int PER_W  = 8;
    localparam int SW     = 3;
    localparam int NP     = 100;
    localparam int PER    = (NP + 1) * CE_DIV;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [SW-1:0]    wr_addr = '0;
    logic [7:0]       wr_data = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [PER_W-1:0] n_per = '0;
    logic [SW-1:0]    n_step = '0;
    logic             co_msaw;
    logic             ce;
    logic [7:0]       M;
    logic             busy;
    logic             done;
    logic [SW-1:0]    step_idx;

    int checks = 0;
    int fails  = 0;
    int gcnt;
    logic [7:0] tbl_m [NSTEP];

    always #5 clk = ~clk;

    agn_msaw_seq #(
        .NSTEP (NSTEP),
        .CE_DIV(CE_DIV),
        .PER_W (PER_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .n_per   (n_per),
        .n_step  (n_step),
        .co_msaw (co_msaw),
        .ce      (ce),
        .M       (M),
        .busy    (busy),
        .done    (done),
        .step_idx(step_idx)
    );

    // free-running sawtooth counter, advanced only on ce
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gcnt <= 0;
        else if (ce)
            gcnt <= (gcnt == NP) ? 0 : gcnt + 1;
    end
    assign co_msaw = (gcnt == NP);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // step reached after a given number of generator wraps since start
    function automatic int step_of(int wraps, int npe, int nst);
        int s;
        s = (wraps - 1) / npe;
`ifdef AGN_SEQ_LOOP_EN
        s = s % nst;
`endif
        return s;
    endfunction

    function automatic int exp_m(int wraps, int npe, int nst);
        int s;
        if (wraps == 0) return 0;
        s = step_of(wraps, npe, nst);
        if (s >= nst) return 0;
        return int'(tbl_m[s]);
    endfunction

    task automatic wr(input int a, input int d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = SW'(a);
        wr_data  = 8'(d);
        chk("wr_ready_idle", wr_ready, 1);
        tbl_m[a] = 8'(d);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic clr_model();
        for (int i = 0; i < NSTEP; i++)
            tbl_m[i] = 8'd0;
    endtask

    // abort: 0 none, 1 stop, 2 async reset; stop_at = run period index of the abort
    task automatic run_seq(input int np, input int ns, input int abort, input int stop_at,
                           input bit lock, input int sw);
        int npe, nst, total, wraps, cyc, last_w, last_sc, bound, dn;
        bit post, fin, last;
        npe = (np == 0) ? 1 : np;
        nst = ns + 1;
        total = nst * npe;
`ifdef AGN_SEQ_LOOP_EN
        if (abort == 0) begin
            abort = 1;
            stop_at = 3 * total;
        end
`endif
        bound = ((stop_at >= 0) ? stop_at + 3 : total + 3) * PER + 400;
        @(negedge clk);
        start  = 1'b1;
        n_per  = PER_W'(np);
        n_step = SW'(ns);
        if (sw >= 0) begin
            wr_valid = 1'b1;
            wr_addr  = '0;
            wr_data  = 8'(sw);
            tbl_m[0] = 8'(sw);
            chk("wr_ready_start", wr_ready, 1);
        end
        @(negedge clk);
        start    = 1'b0;
        wr_valid = lock;
        wr_addr  = '0;
        wr_data  = 8'hff;
        chk("busy_start", busy, 1);
        chk("m_sync", M, 0);
        wraps = 0; cyc = 0; last_w = 0; last_sc = 0; post = 0; fin = 0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc > bound) begin
                chk("timeout", 0, 1);
                wr_valid = 1'b0;
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
                clr_model();
                fin = 1;
            end else begin
`ifdef AGN_SEQ_LOOP_EN
                last = 1'b0;
`else
                last = (wraps == total + 1);
`endif
                if (post && last) begin
                    wr_valid = 1'b0;
                    chk("done_pulse", done, 1);
                    chk("done_ce", ce, 0);
                    chk("done_m", M, 0);
                    chk("done_busy", busy, 1);
                    @(negedge clk);
                    chk("idle_busy", busy, 0);
                    chk("idle_done", done, 0);
                    chk("idle_wr_ready", wr_ready, 1);
                    fin = 1;
                end else if (post) begin
                    chk("m_post", M, exp_m(wraps, npe, nst));
                    chk("step_idx", step_idx, step_of(wraps, npe, nst));
                end
            end
            if (!fin) begin
                post = 0;
                if (ce && co_msaw) begin
                    chk("m_pre", M, exp_m(wraps, npe, nst));
                    chk("no_done", done, 0);
                    if (lock) chk("wr_lock", wr_ready, 0);
                    wraps++;
                    post = 1;
                    if (wraps >= 2) chk("per_len", cyc - last_w, PER);
                    if (wraps >= 2 && (wraps - 1) % npe == 0)
                        chk("step_len", cyc - last_sc, npe * PER);
                    if ((wraps - 1) % npe == 0) last_sc = cyc;
                    last_w = cyc;
                end else if (abort != 0 && wraps == stop_at + 1 && cyc - last_w == 40) begin
                    wr_valid = 1'b0;
                    if (abort == 1) begin
                        stop = 1'b1;
                        @(negedge clk);
                        stop = 1'b0;
                        chk("stop_m", M, 0);
                        chk("stop_ce", ce, 0);
                        chk("stop_busy", busy, 0);
                        chk("stop_step", step_idx, 0);
                        dn = int'(done);
                        repeat (4) begin
                            @(negedge clk);
                            dn = dn | int'(done);
                        end
                        chk("stop_no_done", dn, 0);
                    end else begin
                        #3 rst_n = 1'b0;
                        #1;
                        chk("rst_ce", ce, 0);
                        chk("rst_m", M, 0);
                        chk("rst_busy", busy, 0);
                        chk("rst_done", done, 0);
                        chk("rst_step", step_idx, 0);
                        chk("rst_wr_ready", wr_ready, 1);
                        clr_model();
                        @(negedge clk);
                        rst_n = 1'b1;
                    end
                    fin = 1;
                end
                if (!fin && wraps == 1 && !post && cyc - last_w == 7) begin
                    start  = 1'b1;
                    n_per  = PER_W'(3);
                    n_step = SW'(7);
                end
            end
        end
        wr_valid = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        int np, ns, ab, sa, sw;
        clr_model();
        repeat (3) @(negedge clk);
        chk("rst0_ce", ce, 0);
        chk("rst0_m", M, 0);
        chk("rst0_busy", busy, 0);
        chk("rst0_done", done, 0);
        chk("rst0_step", step_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst0_wr_ready", wr_ready, 1);

        wr(0, 16); wr(1, 32); wr(2, 64); wr(3, 128);
        for (int i = 4; i < NSTEP; i++) wr(i, int'($urandom_range(1, 255)));

        run_seq(2, 3, 0, -1, 1'b0, -1);
        run_seq(2, 3, 1, 4, 1'b0, -1);
        run_seq(2, 3, 0, -1, 1'b1, -1);
        run_seq(1, 0, 0, -1, 1'b0, -1);
        run_seq(0, 1, 0, -1, 1'b0, -1);

        repeat (3) begin
            wr(int'($urandom_range(0, NSTEP - 1)), int'($urandom_range(0, 255)));
            np = int'($urandom_range(0, 2));
            ns = int'($urandom_range(0, 2));
            ab = int'($urandom_range(0, 1));
            sa = ab ? int'($urandom_range(0, ((np == 0) ? 1 : np) * (ns + 1) - 1)) : -1;
            sw = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : -1;
            run_seq(np, ns, ab, sa, 1'b0, sw);
        end

        run_seq(2, 3, 2, 3, 1'b0, -1);
        run_seq(1, 3, 0, -1, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
